// File: rtl/bus_cycle_ctrl_if.sv
// Request/bus signal bundle for bus_cycle_ctrl.
// master = requester and external bus side, slave = the cycle controller.
interface bus_cycle_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              req;
    logic [1:0]        req_type;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              ready;
    logic [DATA_W-1:0] data_in;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              ale;
    logic              S0;
    logic              S1;
    logic              IO_Mn;
    logic              RDn;
    logic              WRn;
    logic [ADDR_W-1:0] ADD;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;
    logic [2:0]        state;

    modport master (
        output req, req_type, req_addr, req_wdata, ready, data_in,
        input  busy, done, rdata, ale, S0, S1, IO_Mn, RDn, WRn, ADD,
               data_out, data_oe, state
    );

    modport slave (
        input  req, req_type, req_addr, req_wdata, ready, data_in,
        output busy, done, rdata, ale, S0, S1, IO_Mn, RDn, WRn, ADD,
               data_out, data_oe, state
    );
endinterface

// File: rtl/bus_cycle_ctrl.sv
// Machine-cycle controller: sequences T1/T2/TW/T3 bus cycles with
// status, strobes, address latch enable and forced/external wait states.
module bus_cycle_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MIN_WAIT = 0,
    parameter int MUX_AD   = 1
) (
    input logic            clk,
    input logic            rst,
    bus_cycle_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE = 3'b000,
        T1   = 3'b001,
        T2   = 3'b010,
        TW   = 3'b011,
        T3   = 3'b100
    } state_t;

    state_t            cur, nxt;
    logic [1:0]        type_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [2:0]        wait_q;
    logic              done_q;
    logic              accept;
    logic              is_wr;
    logic              is_rd;

    assign accept = bus.req && (cur == IDLE || cur == T3);
    assign is_wr  = type_q[0];
    assign is_rd  = !type_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur     <= IDLE;
            type_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wait_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            cur    <= nxt;
            done_q <= (cur == T3);
            if (accept) begin
                type_q  <= bus.req_type;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            // Decrementing in T2 as well as TW makes the wait-state count
            // exactly max(MIN_WAIT, cycles of ready low from T2 onward).
            if (cur == T1)
                wait_q <= 3'(MIN_WAIT);
            else if ((cur == T2 || cur == TW) && wait_q != '0)
                wait_q <= wait_q - 3'd1;
            if (cur == T3 && is_rd)
                rdata_q <= bus.data_in;
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:    if (accept) nxt = T1;
            T1:      nxt = T2;
            T2, TW:  nxt = (wait_q != '0 || !bus.ready) ? TW : T3;
            T3:      nxt = accept ? T1 : IDLE;
            default: nxt = IDLE;
        endcase
    end

    logic              ale_c, s0_c, s1_c, io_c, rdn_c, wrn_c, oe_c;
    logic [DATA_W-1:0] dout_c;

    always_comb begin
        ale_c  = 1'b0;
        s0_c   = 1'b0;
        s1_c   = 1'b0;
        io_c   = 1'b0;
        rdn_c  = 1'b1;
        wrn_c  = 1'b1;
        oe_c   = 1'b0;
        dout_c = '0;
        if (cur != IDLE) begin
            io_c = type_q[1];
            s1_c = is_rd;
            s0_c = is_wr;
        end
        if (cur == T1) begin
            ale_c = 1'b1;
            if (MUX_AD != 0) begin
                dout_c = addr_q[DATA_W-1:0];
                oe_c   = 1'b1;
            end else if (is_wr) begin
                dout_c = wdata_q;
                oe_c   = 1'b1;
            end
        end
        if (cur == T2 || cur == TW || cur == T3) begin
            rdn_c = !is_rd;
            wrn_c = !is_wr;
            if (is_wr) begin
                dout_c = wdata_q;
                oe_c   = 1'b1;
            end
        end
    end

    assign bus.busy     = (cur != IDLE);
    assign bus.done     = done_q;
    assign bus.rdata    = rdata_q;
    assign bus.ale      = ale_c;
    assign bus.S0       = s0_c;
    assign bus.S1       = s1_c;
    assign bus.IO_Mn    = io_c;
    assign bus.RDn      = rdn_c;
    assign bus.WRn      = wrn_c;
    assign bus.ADD      = addr_q;
    assign bus.data_out = dout_c;
    assign bus.data_oe  = oe_c;
    assign bus.state    = cur;
endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Bench for bus_cycle_ctrl: two instances (MIN_WAIT=0/MUX_AD=1 and
// MIN_WAIT=2/MUX_AD=0) checked every cycle against a planned timeline.
module tb_bus_cycle_ctrl;
    localparam int NC = 80;

    typedef struct {
        int          ph;
        logic [1:0]  typ;
        logic [15:0] addr;
        logic [7:0]  wd;
        bit          done;
        bit          rdv;
        logic [7:0]  rdval;
        bit          rst;
    } exp_t;

    typedef struct {
        bit          req;
        logic [1:0]  typ;
        logic [15:0] addr;
        logic [7:0]  wd;
        bit          rdy;
        logic [7:0]  din;
        bit          rst;
    } stim_t;

    typedef struct {
        logic [2:0]  st;
        logic        busy, done, ale, s0, s1, io, rdn, wrn, doe;
        logic [15:0] add;
        logic [7:0]  dout, rdata;
    } out_t;

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    always #5 clk = ~clk;

    bus_cycle_ctrl_if #(.ADDR_W(16), .DATA_W(8)) bus0 ();
    bus_cycle_ctrl_if #(.ADDR_W(16), .DATA_W(8)) bus1 ();

    bus_cycle_ctrl #(.ADDR_W(16), .DATA_W(8), .MIN_WAIT(0), .MUX_AD(1))
        dut0 (.clk(clk), .rst(rst0), .bus(bus0));
    bus_cycle_ctrl #(.ADDR_W(16), .DATA_W(8), .MIN_WAIT(2), .MUX_AD(0))
        dut1 (.clk(clk), .rst(rst1), .bus(bus1));

    exp_t        ex  [2][NC];
    stim_t       sm  [2][NC];
    logic [7:0]  rde [2][NC];
    bit          mux [2] = '{1'b1, 1'b0};
    int          minw[2] = '{0, 2};
    int          nerr = 0;
    int          nchk = 0;
    int          cur  = -1;

    task automatic chk(string nm, int d, int c, logic [31:0] got, logic [31:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s dut%0d cycle %0d got %0h want %0h", nm, d, c, got, want);
        end
    endtask

    // A cycle requested in cycle a runs T1 at a+1, T2 at a+2, then
    // max(MIN_WAIT, low) wait states, T3, and done the cycle after T3.
    task automatic add_txn(int d, int a, logic [1:0] t, logic [15:0] ad,
                           logic [7:0] wd, logic [7:0] rd, int low);
        int w, t3;
        w  = (minw[d] > low) ? minw[d] : low;
        t3 = a + 3 + w;
        sm[d][a].req  = 1'b1;
        sm[d][a].typ  = t;
        sm[d][a].addr = ad;
        sm[d][a].wd   = wd;
        for (int k = 0; k < low; k++) sm[d][a + 2 + k].rdy = 1'b0;
        sm[d][t3].din = rd;
        for (int c = a + 1; c <= t3; c++) begin
            ex[d][c].ph   = (c == a + 1) ? 1 : (c == a + 2) ? 2 : (c == t3) ? 4 : 3;
            ex[d][c].typ  = t;
            ex[d][c].addr = ad;
            ex[d][c].wd   = wd;
        end
        ex[d][t3 + 1].done  = 1'b1;
        ex[d][t3 + 1].rdv   = !t[0];
        ex[d][t3 + 1].rdval = rd;
    endtask

    task automatic add_rst(int d, int r, int span);
        sm[d][r].rst = 1'b1;
        ex[d][r].rst = 1'b1;
        for (int c = r; c <= r + span; c++) begin
            ex[d][c].ph   = 0;
            ex[d][c].done = 1'b0;
            ex[d][c].rdv  = 1'b0;
        end
    endtask

    task automatic drive(int c);
        bus0.req       = sm[0][c].req;
        bus0.req_type  = sm[0][c].typ;
        bus0.req_addr  = sm[0][c].addr;
        bus0.req_wdata = sm[0][c].wd;
        bus0.ready     = sm[0][c].rdy;
        bus0.data_in   = sm[0][c].din;
        rst0           = sm[0][c].rst;
        bus1.req       = sm[1][c].req;
        bus1.req_type  = sm[1][c].typ;
        bus1.req_addr  = sm[1][c].addr;
        bus1.req_wdata = sm[1][c].wd;
        bus1.ready     = sm[1][c].rdy;
        bus1.data_in   = sm[1][c].din;
        rst1           = sm[1][c].rst;
    endtask

    task automatic cmp(int d, int c, out_t o);
        exp_t e;
        bit   wr, act, mid, doe_e;
        logic [7:0] dexp;
        e     = ex[d][c];
        wr    = e.typ[0];
        act   = (e.ph != 0);
        mid   = (e.ph >= 2);
        doe_e = act && ((e.ph == 1) ? (mux[d] || wr) : wr);
        dexp  = (e.ph == 1 && mux[d]) ? e.addr[7:0] : e.wd;
        chk("state", d, c, 32'(o.st),   32'(e.ph));
        chk("busy",  d, c, 32'(o.busy), 32'(act));
        chk("done",  d, c, 32'(o.done), 32'(e.done));
        chk("ale",   d, c, 32'(o.ale),  32'(e.ph == 1));
        chk("S1",    d, c, 32'(o.s1),   32'(act && !wr));
        chk("S0",    d, c, 32'(o.s0),   32'(act && wr));
        chk("IO_Mn", d, c, 32'(o.io),   32'(act && e.typ[1]));
        chk("RDn",   d, c, 32'(o.rdn),  32'(!(mid && !wr)));
        chk("WRn",   d, c, 32'(o.wrn),  32'(!(mid && wr)));
        chk("data_oe", d, c, 32'(o.doe), 32'(doe_e));
        chk("rdata", d, c, 32'(o.rdata), 32'(rde[d][c]));
        if (act)   chk("ADD", d, c, 32'(o.add), 32'(e.addr));
        if (doe_e) chk("data_out", d, c, 32'(o.dout), 32'(dexp));
        if (e.rst) begin
            chk("rst_ADD",      d, c, 32'(o.add),  32'h0);
            chk("rst_data_out", d, c, 32'(o.dout), 32'h0);
        end
        // Hand-computed anchors for the scenarios above.
        if (d == 0 && c == 9)  begin chk("pin_rd_done", d, c, 32'(o.done), 32'h1);
                                     chk("pin_rd_data", d, c, 32'(o.rdata), 32'hA5); end
        if (d == 0 && c == 7)  chk("pin_rdn_low", d, c, 32'(o.rdn), 32'h0);
        if (d == 0 && c == 13) chk("pin_t1_mux_addr", d, c, 32'(o.dout), 32'h42);
        if (d == 0 && c == 14) begin chk("pin_io_wdata", d, c, 32'(o.dout), 32'h3C);
                                     chk("pin_io_wrn", d, c, 32'(o.wrn), 32'h0);
                                     chk("pin_io_mn", d, c, 32'(o.io), 32'h1); end
        if (d == 0 && c == 36) begin chk("pin_b2b_state", d, c, 32'(o.st), 32'h1);
                                     chk("pin_b2b_done", d, c, 32'(o.done), 32'h1);
                                     chk("pin_b2b_rdata", d, c, 32'(o.rdata), 32'h11); end
        if (d == 0 && c == 54) begin chk("pin_rst_state", d, c, 32'(o.st), 32'h0);
                                     chk("pin_rst_wrn", d, c, 32'(o.wrn), 32'h1);
                                     chk("pin_rst_oe", d, c, 32'(o.doe), 32'h0); end
        if (d == 0 && c == 66) chk("pin_after_rst_rdata", d, c, 32'(o.rdata), 32'h3E);
        if (d == 1 && c == 11) chk("pin_tw_last", d, c, 32'(o.st), 32'h3);
        if (d == 1 && c == 12) chk("pin_t3", d, c, 32'(o.st), 32'h4);
        if (d == 1 && c == 13) begin chk("pin_wait_done", d, c, 32'(o.done), 32'h1);
                                     chk("pin_wait_rdata", d, c, 32'(o.rdata), 32'hA5); end
        if (d == 1 && c == 21) chk("pin_nomux_t1_wdata", d, c, 32'(o.dout), 32'h3C);
    endtask

    always @(negedge clk) begin
        out_t o0, o1;
        if (cur >= 0) begin
            o0.st = bus0.state; o0.busy = bus0.busy; o0.done = bus0.done;
            o0.ale = bus0.ale; o0.s0 = bus0.S0; o0.s1 = bus0.S1; o0.io = bus0.IO_Mn;
            o0.rdn = bus0.RDn; o0.wrn = bus0.WRn; o0.doe = bus0.data_oe;
            o0.add = bus0.ADD; o0.dout = bus0.data_out; o0.rdata = bus0.rdata;
            o1.st = bus1.state; o1.busy = bus1.busy; o1.done = bus1.done;
            o1.ale = bus1.ale; o1.s0 = bus1.S0; o1.s1 = bus1.S1; o1.io = bus1.IO_Mn;
            o1.rdn = bus1.RDn; o1.wrn = bus1.WRn; o1.doe = bus1.data_oe;
            o1.add = bus1.ADD; o1.dout = bus1.data_out; o1.rdata = bus1.rdata;
            cmp(0, cur, o0);
            cmp(1, cur, o1);
        end
    end

    initial begin
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < NC; c++) begin
                sm[d][c] = '{req: 1'b0, typ: 2'b00, addr: 16'h0, wd: 8'h0,
                             rdy: 1'b1, din: 8'(c * 37 + 11), rst: (c < 3)};
                ex[d][c] = '{ph: 0, typ: 2'b00, addr: 16'h0, wd: 8'h0,
                             done: 1'b0, rdv: 1'b0, rdval: 8'h0, rst: (c < 3)};
            end

        // Fast instance: plain read, IO write, read with ready ignored outside
        // T2/TW and req ignored mid-cycle, back-to-back chain, reset in TW.
        add_txn(0,  5, 2'b00, 16'h2050, 8'h00, 8'hA5, 0);
        add_txn(0, 12, 2'b11, 16'h0042, 8'h3C, 8'h00, 0);
        add_txn(0, 20, 2'b00, 16'h1234, 8'h00, 8'h5A, 3);
        for (int c = 21; c <= 25; c++) begin
            sm[0][c].req = 1'b1; sm[0][c].typ = 2'b01;
            sm[0][c].addr = 16'hFFFF; sm[0][c].wd = 8'hEE;
        end
        sm[0][21].rdy = 1'b0;
        sm[0][26].rdy = 1'b0;
        add_txn(0, 32, 2'b00, 16'h0100, 8'h00, 8'h11, 0);
        add_txn(0, 35, 2'b01, 16'h0200, 8'h77, 8'h00, 0);
        add_txn(0, 38, 2'b10, 16'h0300, 8'h00, 8'hC3, 1);
        add_txn(0, 50, 2'b01, 16'hABCD, 8'h99, 8'h00, 6);
        add_rst(0, 54, 6);
        add_txn(0, 62, 2'b00, 16'h0555, 8'h00, 8'h3E, 0);

        // MIN_WAIT=2, non-multiplexed instance.
        add_txn(1,  5, 2'b00, 16'h2050, 8'h00, 8'hA5, 4);
        add_txn(1, 20, 2'b01, 16'h0042, 8'h3C, 8'h00, 0);
        add_txn(1, 30, 2'b10, 16'h0077, 8'h00, 8'h81, 1);

        for (int d = 0; d < 2; d++) begin
            logic [7:0] v;
            v = 8'h00;
            for (int c = 0; c < NC; c++) begin
                if (ex[d][c].rst) v = 8'h00;
                if (ex[d][c].rdv) v = ex[d][c].rdval;
                rde[d][c] = v;
            end
        end

        drive(0);
        rst0 = 1'b1;
        rst1 = 1'b1;
        for (int c = 0; c < NC; c++) begin
            @(posedge clk);
            #1;
            cur = c;
            drive(c);
        end
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/bus_cycle_ctrl.md
BUS_CYCLE_CTRL -- requirements
Module: bus_cycle_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width (8..32).
REQ-002 SHALL have parameter DATA_W, default 8, data width (8 or 16); DATA_W <= ADDR_W.
REQ-003 SHALL have parameter MIN_WAIT, default 0, forced wait states per cycle (0..7).
REQ-004 SHALL have parameter MUX_AD, default 1, 1 = address low byte multiplexed on data bus during T1.
REQ-005 SHALL have ports, in order:
clk  in  1  single clock, all state on rising edge.
rst  in  1  asynchronous, active-high reset.
req  in  1  machine-cycle request.
req_type  in  2  00 mem read, 01 mem write, 10 IO read, 11 IO write.
req_addr  in  ADDR_W  cycle address.
req_wdata  in  DATA_W  write data.
ready  in  1  external ready; low inserts wait states.
data_in  in  DATA_W  bus read data.
busy  out  1  state != IDLE.
done  out  1  one-cycle completion pulse.
rdata  out  DATA_W  captured read data.
ale  out  1  address latch enable.
S0  out  1  status bit 0.
S1  out  1  status bit 1.
IO_Mn  out  1  1 = IO cycle, 0 = memory cycle.
RDn  out  1  read strobe, active low.
WRn  out  1  write strobe, active low.
ADD  out  ADDR_W  address bus.
data_out  out  DATA_W  driven data.
data_oe  out  1  data bus output enable.
state  out  3  IDLE 000, T1 001, T2 010, TW 011, T3 100.

Function
REQ-006 SHALL accept a request when req=1 and state is IDLE or T3; on acceptance it SHALL register req_type, req_addr and req_wdata, and the next state SHALL be T1.
REQ-007 SHALL ignore req in T1, T2 and TW; registered request fields SHALL stay stable until the cycle ends.
REQ-008 T1: ale=1; ADD=registered address; MUX_AD=1 -> data_out=addr[DATA_W-1:0] and data_oe=1; MUX_AD=0 -> data_oe=0 unless write.
REQ-009 T1 through T3: IO_Mn=type[1]; S1S0=10 for reads and 01 for writes; IDLE: S1S0=00, IO_Mn=0.
REQ-010 T2 through T3 inclusive: RDn=0 for reads, WRn=0 for writes; RDn and WRn SHALL never be low simultaneously.
REQ-011 Writes: data_out=registered wdata and data_oe=1 from T2 through T3; reads: data_oe=0 from T2 onward.
REQ-012 On entering T2, a wait counter SHALL load MIN_WAIT.
REQ-013 From T2 or TW the next state SHALL be TW if counter>0 or ready=0, else T3; the counter SHALL decrement, saturating at 0, in each TW.
REQ-014 ready SHALL be sampled only in T2 and TW and ignored elsewhere.
REQ-015 Reads: rdata SHALL capture data_in on the clock edge that ends T3 and hold until the next read completes.
REQ-016 done SHALL be 1 for exactly the cycle after T3, with rdata valid in that cycle.
REQ-017 Zero-wait latency: accept at edge N -> T1 N+1, T2 N+2, T3 N+3, done N+4; each wait state adds one cycle.
REQ-018 With req=1 in T3 (back-to-back), the next state SHALL be T1 and the done pulse SHALL coincide with that T1.
REQ-019 ale SHALL be 0 in every state other than T1.

Reset
REQ-020 rst=1 SHALL immediately force state=IDLE, counter=0, ale=0, RDn=1, WRn=1, S0=S1=0, IO_Mn=0, data_oe=0, done=0, busy=0, ADD=0, data_out=0, rdata=0, independent of clk.
REQ-021 Reset asserted mid-cycle (any state) SHALL abort the cycle with no done pulse; the first cycle after deassertion SHALL be IDLE.

Verification
REQ-022 Mem read, MIN_WAIT=0, ready=1, addr 0x2050, data_in=0xA5 in T3 -> states 001,010,100; RDn low 2 cycles; S1S0=10; done at N+4; rdata=0xA5.
REQ-023 IO write, addr 0x0042, wdata 0x3C -> IO_Mn=1, S1S0=01, WRn low T2-T3, data_out=0x3C with data_oe=1; in T1 (MUX_AD=1) data_out=0x42.
REQ-024 MIN_WAIT=2 with ready held low 4 cycles after T2 -> TW count = max(2,4) = 4; done at N+8.
REQ-025 Back-to-back read then write with req held high -> second T1 directly follows first T3; done pulse coincides with second T1; no IDLE cycle between them.
REQ-026 rst pulsed during TW of a write -> WRn=1, data_oe=0 and state=000 immediately, with no done pulse; a subsequent read completes normally.
